regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the RV32 register file. It shares the register file's single write port (A3/WD3/WE3) between the in-order pipeline writeback stage and a long-latency multicycle unit (divider / miss handler). Multicycle results that cannot be written immediately are held in a 2-entry buffer. A 31-bit busy scoreboard produces the decode-stage hazard stall. The block sits between the WB stage, the multicycle unit and the register file instance.

---
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle around the register-file write-port arbiter: WB stage, multicycle unit,
// decode-stage hazard query and the register file's single write port.
interface regfile_wb_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;

  // master: the pipeline / multicycle side; slave: the arbiter
  modport master (
    output wb_we, wb_rd, wb_data,
    output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    output dec_rs1, dec_rs2, dec_rd,
    input  mc_ready, stall, pipe_hold, rf_we, rf_a3, rf_wd, busy_mask
  );

  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    input  dec_rs1, dec_rs2, dec_rd,
    output mc_ready, stall, pipe_hold, rf_we, rf_a3, rf_wd, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between WB and a multicycle unit, with a 2-entry
// result buffer, a busy scoreboard for decode hazards and a starvation hold request.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      buf_reg [2];
  logic        head_reg;
  logic [1:0]  count_reg;
  logic [3:0]  starve_reg;
  logic        hold_reg;
  logic [31:1] busy_reg;

  logic        empty;
  logic        full;
  logic        tail;
  entry_t      head_entry;
  logic        wb_win;
  logic        pop;
  logic        bypass;
  logic        accept;
  logic        push;
  logic        mc_write;
  logic [4:0]  mc_write_rd;
  logic [31:0] busy_mask_w;

  logic        head_next;
  logic [1:0]  count_next;
  logic [3:0]  starve_next;
  logic [31:1] busy_next;
  logic        rf_we_next;
  logic [4:0]  rf_a3_next;
  logic [31:0] rf_wd_next;
  logic        stall_next;

  assign empty      = (count_reg == 2'd0);
  assign full       = (count_reg == 2'd2);
  assign head_entry = buf_reg[head_reg];
  // Only pushed when not full, so the free slot is head (empty) or head^1 (one entry).
  assign tail       = head_reg ^ count_reg[0];

  // Strict priority: WB, then buffer head, then bypass of a fresh result.
  assign wb_win = bus.wb_we && (bus.wb_rd != 5'd0);
  assign pop    = !wb_win && !empty;
  assign bypass = !wb_win && empty && bus.mc_valid && (bus.mc_rd != 5'd0);
  assign accept = bus.mc_valid && !full;
  // x0 results are accepted but dropped on the floor.
  assign push   = accept && (bus.mc_rd != 5'd0) && !bypass;

  assign mc_write    = pop || bypass;
  assign mc_write_rd = pop ? head_entry.rd : bus.mc_rd;

  assign head_next  = pop ? ~head_reg : head_reg;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_comb begin
    starve_next = 4'd0;
    if (!empty && !pop) begin
      starve_next = (starve_reg == 4'hF) ? starve_reg : starve_reg + 4'd1;
    end
  end

  // Set from an issue wins over a clear from a same-cycle mc-path write.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (bus.mc_issue && (bus.mc_issue_rd == 5'(gi)))
                          || (busy_reg[gi] && !(mc_write && (mc_write_rd == 5'(gi))));
    end
  endgenerate

  assign busy_mask_w = {busy_reg, 1'b0};

  function automatic logic hazard(input logic [4:0] r, input logic [31:0] mask,
                                  input logic wr, input logic [4:0] wr_rd);
    return (r != 5'd0) && mask[r] && !(wr && (wr_rd == r));
  endfunction

  always_comb begin
    rf_we_next = 1'b0;
    rf_a3_next = 5'd0;
    rf_wd_next = 32'd0;
    stall_next = 1'b0;
    if (!rst) begin
      if (wb_win) begin
        rf_we_next = 1'b1;
        rf_a3_next = bus.wb_rd;
        rf_wd_next = bus.wb_data;
      end else if (pop) begin
        rf_we_next = 1'b1;
        rf_a3_next = head_entry.rd;
        rf_wd_next = head_entry.data;
      end else if (bypass) begin
        rf_we_next = 1'b1;
        rf_a3_next = bus.mc_rd;
        rf_wd_next = bus.mc_data;
      end
      // The register file forwards WD3, so a register written this cycle no longer stalls.
      stall_next = hazard(bus.dec_rs1, busy_mask_w, mc_write, mc_write_rd)
                 | hazard(bus.dec_rs2, busy_mask_w, mc_write, mc_write_rd)
                 | hazard(bus.dec_rd,  busy_mask_w, mc_write, mc_write_rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg   <= 1'b0;
      count_reg  <= 2'd0;
      starve_reg <= 4'd0;
      hold_reg   <= 1'b0;
      busy_reg   <= '0;
    end else begin
      head_reg   <= head_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      hold_reg   <= (starve_next >= LIMIT);
      busy_reg   <= busy_next;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_reg[tail] <= {bus.mc_rd, bus.mc_data};
    end
  end

  assign bus.mc_ready  = !full;
  assign bus.stall     = stall_next;
  assign bus.pipe_hold = hold_reg;
  assign bus.rf_we     = rf_we_next;
  assign bus.rf_a3     = rf_a3_next;
  assign bus.rf_wd     = rf_wd_next;
  assign bus.busy_mask = busy_mask_w;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked every cycle against a
// queue-based model of the write-port arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy = 32'd0;
  int          m_wait = 0;

  function automatic logic hit(input logic [4:0] r, input logic [31:0] b,
                               input logic w, input logic [4:0] wr);
    return (r != 5'd0) && b[r] && !(w && (wr == r));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_busy = 32'd0;
      m_wait = 0;
    end else begin
      automatic int          n   = q.size();
      automatic logic        wb  = bus.wb_we && (bus.wb_rd != 5'd0);
      automatic logic        popped = !wb && (n > 0);
      automatic logic        byp = !wb && (n == 0) && bus.mc_valid && (bus.mc_rd != 5'd0);
      automatic logic [4:0]  clr = 5'd0;
      if (popped) begin
        clr = q[0].rd;
        void'(q.pop_front());
      end else if (byp) begin
        clr = bus.mc_rd;
      end
      if (bus.mc_valid && (n < 2) && (bus.mc_rd != 5'd0) && !byp)
        q.push_back('{bus.mc_rd, bus.mc_data});
      if (clr != 5'd0) m_busy[clr] = 1'b0;
      if (bus.mc_issue && (bus.mc_issue_rd != 5'd0)) m_busy[bus.mc_issue_rd] = 1'b1;
      if ((n > 0) && !popped) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
      else m_wait = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    automatic logic        e_we = 1'b0;
    automatic logic [4:0]  e_a3 = 5'd0;
    automatic logic [31:0] e_wd = 32'd0;
    automatic logic        e_ready = 1'b1;
    automatic logic        e_stall = 1'b0;
    automatic logic        e_hold = 1'b0;
    automatic logic [31:0] e_busy = 32'd0;
    automatic logic        mcw = 1'b0;
    automatic logic [4:0]  mcw_rd = 5'd0;
    if (!rst) begin
      if (bus.wb_we && (bus.wb_rd != 5'd0)) begin
        e_we = 1'b1; e_a3 = bus.wb_rd; e_wd = bus.wb_data;
      end else if (q.size() > 0) begin
        e_we = 1'b1; e_a3 = q[0].rd; e_wd = q[0].data; mcw = 1'b1; mcw_rd = q[0].rd;
      end else if (bus.mc_valid && (bus.mc_rd != 5'd0)) begin
        e_we = 1'b1; e_a3 = bus.mc_rd; e_wd = bus.mc_data; mcw = 1'b1; mcw_rd = bus.mc_rd;
      end
      e_ready = (q.size() < 2);
      e_hold  = (m_wait >= LIMIT);
      e_busy  = m_busy;
      e_stall = hit(bus.dec_rs1, m_busy, mcw, mcw_rd) | hit(bus.dec_rs2, m_busy, mcw, mcw_rd)
              | hit(bus.dec_rd, m_busy, mcw, mcw_rd);
    end
    chk("model rf_we", 32'(bus.rf_we), 32'(e_we));
    chk("model rf_a3", 32'(bus.rf_a3), 32'(e_a3));
    chk("model rf_wd", bus.rf_wd, e_wd);
    chk("model mc_ready", 32'(bus.mc_ready), 32'(e_ready));
    chk("model stall", 32'(bus.stall), 32'(e_stall));
    chk("model pipe_hold", 32'(bus.pipe_hold), 32'(e_hold));
    chk("model busy_mask", bus.busy_mask, e_busy);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.mc_issue = 1'b0; bus.mc_issue_rd = 5'd0;
    bus.mc_valid = 1'b0; bus.mc_rd = 5'd0; bus.mc_data = 32'd0;
    bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic mc(input logic [4:0] rd, input logic [31:0] d);
    bus.mc_valid = 1'b1; bus.mc_rd = rd; bus.mc_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.mc_issue = 1'b1; bus.mc_issue_rd = rd;
  endtask

  initial begin
    idle();
    // Reset held with live inputs
    wb(5'd3, 32'h1234);
    mc(5'd6, 32'h5678);
    tick(); tick();
    @(negedge clk);
    $display("txn reset-hold");
    chk("rst rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst rf_wd", bus.rf_wd, 32'd0);
    chk("rst mc_ready", 32'(bus.mc_ready), 32'd1);
    tick();
    rst = 1'b0;
    idle();

    // Priority: WB beats mc; x7 waits one cycle
    wb(5'd3, 32'h11); mc(5'd7, 32'h22);
    @(negedge clk);
    $display("txn priority wb x3 vs mc x7");
    chk("prio a3", 32'(bus.rf_a3), 32'd3);
    chk("prio wd", bus.rf_wd, 32'h11);
    tick(); idle();
    @(negedge clk);
    $display("txn drain x7");
    chk("prio drain a3", 32'(bus.rf_a3), 32'd7);
    chk("prio drain wd", bus.rf_wd, 32'h22);
    tick();

    // Scoreboard: issue x9, decode rs2=9 stalls until written
    issue(5'd9);
    @(negedge clk);
    $display("txn issue x9");
    chk("sb busy before", bus.busy_mask, 32'd0);
    tick(); idle(); bus.dec_rs2 = 5'd9;
    @(negedge clk);
    $display("txn decode rs2=x9 busy");
    chk("sb stall", 32'(bus.stall), 32'd1);
    chk("sb busy", bus.busy_mask, 32'h0000_0200);
    tick(); mc(5'd9, 32'h99);
    @(negedge clk);
    $display("txn write x9");
    chk("sb stall on write", 32'(bus.stall), 32'd0);
    chk("sb write a3", 32'(bus.rf_a3), 32'd9);
    tick(); idle(); bus.dec_rs2 = 5'd9;
    @(negedge clk);
    chk("sb busy cleared", bus.busy_mask, 32'd0);
    tick();

    // Same-edge issue and write of x4: set wins
    idle(); issue(5'd4);
    tick(); idle(); issue(5'd4); mc(5'd4, 32'h44);
    @(negedge clk);
    $display("txn issue+write x4");
    chk("same a3", 32'(bus.rf_a3), 32'd4);
    tick(); idle();
    @(negedge clk);
    chk("same busy kept", bus.busy_mask, 32'h0000_0010);
    mc(5'd4, 32'h45);
    tick(); idle();
    @(negedge clk);
    chk("same busy cleared", bus.busy_mask, 32'd0);
    tick();

    // Zero register
    mc(5'd0, 32'h5); issue(5'd0);
    @(negedge clk);
    $display("txn x0 result+issue");
    chk("zero rf_we", 32'(bus.rf_we), 32'd0);
    chk("zero ready", 32'(bus.mc_ready), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("zero busy", bus.busy_mask, 32'd0);
    chk("zero ready after", 32'(bus.mc_ready), 32'd1);
    tick();

    // Full buffer and starvation
    wb(5'd1, 32'h100); mc(5'd7, 32'h77);
    @(negedge clk);
    $display("txn full: mc x7");
    chk("full ready c0", 32'(bus.mc_ready), 32'd1);
    tick(); wb(5'd1, 32'h101); mc(5'd8, 32'h88);
    @(negedge clk);
    chk("full ready c1", 32'(bus.mc_ready), 32'd1);
    tick(); wb(5'd1, 32'h102); mc(5'd9, 32'h99);
    @(negedge clk);
    $display("txn full: mc x9 refused");
    chk("full ready c2", 32'(bus.mc_ready), 32'd0);
    chk("full hold c2", 32'(bus.pipe_hold), 32'd0);
    tick();
    @(negedge clk);
    chk("full hold c3", 32'(bus.pipe_hold), 32'd0);
    tick();
    @(negedge clk);
    chk("full hold c4", 32'(bus.pipe_hold), 32'd0);
    tick(); bus.wb_we = 1'b0;
    @(negedge clk);
    $display("txn full: held, drain x7");
    chk("full hold c5", 32'(bus.pipe_hold), 32'd1);
    chk("full a3 c5", 32'(bus.rf_a3), 32'd7);
    chk("full ready c5", 32'(bus.mc_ready), 32'd0);
    tick();
    @(negedge clk);
    $display("txn full: drain x8");
    chk("full a3 c6", 32'(bus.rf_a3), 32'd8);
    chk("full hold c6", 32'(bus.pipe_hold), 32'd0);
    chk("full ready c6", 32'(bus.mc_ready), 32'd1);
    tick(); idle();
    @(negedge clk);
    $display("txn full: drain x9");
    chk("full a3 c7", 32'(bus.rf_a3), 32'd9);
    chk("full wd c7", bus.rf_wd, 32'h99);
    tick();

    // Reset mid-stream with two queued results and busy = x5,x10
    issue(5'd5); tick(); idle(); issue(5'd10); tick(); idle();
    wb(5'd1, 32'h1); mc(5'd5, 32'h55); tick();
    wb(5'd2, 32'h2); mc(5'd10, 32'hAA0); tick();
    idle(); wb(5'd1, 32'h3);
    @(negedge clk);
    $display("txn two queued, busy x5 x10");
    chk("mid busy", bus.busy_mask, 32'h0000_0420);
    chk("mid ready", 32'(bus.mc_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    $display("txn async reset");
    chk("arst busy", bus.busy_mask, 32'd0);
    chk("arst ready", 32'(bus.mc_ready), 32'd1);
    chk("arst rf_we", 32'(bus.rf_we), 32'd0);
    chk("arst rf_a3", 32'(bus.rf_a3), 32'd0);
    tick(); rst = 1'b0; idle(); mc(5'd5, 32'hAA);
    @(negedge clk);
    $display("txn bypass x5 after reset");
    chk("post rst we", 32'(bus.rf_we), 32'd1);
    chk("post rst a3", 32'(bus.rf_a3), 32'd5);
    chk("post rst wd", bus.rf_wd, 32'hAA);
    tick(); idle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      automatic logic [4:0] r = 5'($urandom_range(0, 31));
      automatic int wb_pct = ((c / 200) % 2 == 0) ? 90 : 40;
      rst = ($urandom_range(0, 599) == 0);
      idle();
      if ((m_wait < LIMIT) && ($urandom_range(0, 99) < wb_pct) && !m_busy[r])
        wb(r, $urandom);
      if ($urandom_range(0, 1) == 1) mc(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 2) == 0) issue(5'($urandom_range(0, 31)));
      bus.dec_rs1 = 5'($urandom_range(0, 31));
      bus.dec_rs2 = 5'($urandom_range(0, 31));
      bus.dec_rd  = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
